bnn_layer_sequencer: RTL
========================

// Module: bnn_layer_sequencer
// PURPOSE
//  Sequences one fully-connected binary layer over the 112-bit xnor/popcount datapath.
//  For each output neuron it issues NCHUNK (data chunk, weight row) address pairs, one per
//  cycle, and enables the popcount tree. It accumulates the returned popcounts and compares
//  each neuron total with a threshold. It then writes one output activation bit per neuron.
// PARAMETERS
//  WL      112  bits per chunk; fixes the popcount result range 0..WL (7 bits)
//  NCHUNK  4    chunks per neuron; power of 2, >=2
//  NOUT    64   output neurons per layer; power of 2, >=2
//  PC_LAT  3    cycles from oPC_EN high to matching iPC_VALID (popcount pipeline depth)
//  localparams: CW=clog2(NCHUNK), NW=clog2(NOUT), AW=clog2(NCHUNK*WL+1) (default 9)
// PORTS
//  iCLK         in   1      clock; all state updates on rising edge
//  iRST         in   1      asynchronous reset, active-high
//  iSTART       in   1      1-cycle start pulse; sampled only in IDLE
//  iHOLD        in   1      1 = do not issue this cycle (memory not ready)
//  iTHRESH      in   AW     layer threshold; sampled on an accepted iSTART
//  oDATA_ADDR   out  CW     input-chunk index to the data buffer
//  oWEIGHT_ADDR out  NW+CW  weight-row address = {neuron, chunk}
//  oPC_EN       out  1      popcount enable; high exactly on issue cycles
//  iPC_VALID    in   1      popcount result valid (popcount oEN)
//  iPC_DATA     in   7      popcount result (popcount odata), 0..WL
//  oOUT_WE      out  1      output bit write strobe, 1 cycle per neuron
//  oOUT_ADDR    out  NW     neuron index being written
//  oOUT_BIT     out  1      activation = (neuron total >= threshold)
//  oBUSY        out  1      high from the cycle after start through DONE
//  oDONE        out  1      1-cycle pulse after the last output bit is written
// BEHAVIOUR
//  Reset: all outputs and counters are 0, FSM=IDLE, acc=0, thresh reg=0. Reset mid-layer aborts.
//  No partial results survive reset. Results still in the popcount pipe after reset are ignored.
//  FSM: IDLE -(iSTART)-> ISSUE -(last pair issued)-> DRAIN -(last result retired)-> DONE -> IDLE.
//  ISSUE: if !iHOLD, drive oPC_EN=1 with the current {neuron,chunk}. Advance chunk, then neuron.
//   Advance wraps chunk NCHUNK-1 -> 0 and neuron+1. On iHOLD=1, oPC_EN=0 and addresses hold.
//   Addresses are registered outputs and are stable on the oPC_EN cycle.
//  Issue count: exactly NOUT*NCHUNK enables, in neuron-major order, with no duplicates or skips.
//  Retire side: an independent chunk/neuron counter advances on each iPC_VALID.
//   Results arrive in issue order.
//  Accumulate: acc <= (retire chunk==0 ? 0 : acc) + iPC_DATA. AW bits, unsigned.
//   Max value NCHUNK*WL, so no overflow.
//  On the result with retire chunk==NCHUNK-1, write next cycle:
//   oOUT_WE=1, oOUT_ADDR=retire neuron, oOUT_BIT=(acc+iPC_DATA >= thresh).
//  A write and a new accumulation may happen in the same cycle. Back-to-back neurons cost
//   no bubbles.
//  DRAIN waits until NOUT*NCHUNK results have retired and the final write has been issued.
//  DONE asserts oDONE for 1 cycle. oBUSY drops with the return to IDLE.
//  iSTART is ignored outside IDLE. iSTART with iRST wins for reset.
//  iPC_VALID in IDLE is ignored (no acc or write change).
//  iHOLD in DRAIN/DONE has no effect. Throughput is one pair per cycle when iHOLD=0.
//  Layer latency is NOUT*NCHUNK + PC_LAT + 2 cycles from iSTART to oDONE, plus hold cycles.
// TESTING
//  T1 reset: assert iRST mid-ISSUE -> all outputs 0 the same cycle (async).
//     After release, IDLE, and a stray iPC_VALID causes no oOUT_WE.
//  T2 full layer, iHOLD=0, thresh=224, model popcount PC_LAT=3 ->
//     256 oPC_EN cycles with addr 0..255 in order. 64 writes. oDONE at start+261.
//  T3 threshold edge: neuron 5 chunks return 56,56,56,56 (sum 224), thresh=224 ->
//     bit=1. With thresh=225 -> bit=0. Sum 448 with thresh=448 -> bit=1 (no overflow).
//  T4 hold: random iHOLD 30% -> the address sequence is identical to T2 and no
//     oPC_EN occurs while held. The output bits match the T2 golden model.
//  T5 restart: iSTART pulses during ISSUE/DRAIN are ignored.
//     iSTART the cycle after oDONE -> second layer runs with the new iTHRESH.
//     acc is cleared for neuron 0.
//  T6 all-zero/all-max: iPC_DATA=0 with thresh=0 -> all bits 1.
//     iPC_DATA=112 with thresh=449 -> all bits 0.

Source files
------------

// File: rtl/bnn_layer_sequencer.sv
// bnn_layer_sequencer: issues (chunk, weight row) pairs for one binary FC layer, accumulates popcounts, thresholds and writes one activation bit per neuron.
module bnn_layer_sequencer #(
  parameter int WL = 112,
  parameter int NCHUNK = 4,
  parameter int NOUT = 64,
  parameter int PC_LAT = 3,
  localparam int CW = $clog2(NCHUNK),
  localparam int NW = $clog2(NOUT),
  localparam int AW = $clog2(NCHUNK * WL + 1)
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iSTART,
  input  logic             iHOLD,
  input  logic [AW-1:0]    iTHRESH,
  output logic [CW-1:0]    oDATA_ADDR,
  output logic [NW+CW-1:0] oWEIGHT_ADDR,
  output logic             oPC_EN,
  input  logic             iPC_VALID,
  input  logic [6:0]       iPC_DATA,
  output logic             oOUT_WE,
  output logic [NW-1:0]    oOUT_ADDR,
  output logic             oOUT_BIT,
  output logic             oBUSY,
  output logic             oDONE
);
  localparam int OW = $clog2(PC_LAT + 2) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] chunk_q, chunk_d, rc_q, rc_d;
  logic [NW-1:0] neuron_q, neuron_d, rn_q, rn_d, out_addr_q, out_addr_d;
  logic [AW-1:0] acc_q, acc_d, thresh_q, thresh_d, sum;
  logic [OW-1:0] pend_q, pend_d;
  logic we_q, we_d, bit_q, bit_d, busy_q, busy_d, done_q, done_d;
  logic issue, accept, last_chunk_in, last_issue, retire_last;
  always_comb begin
    issue = state_q == ISSUE && !iHOLD;
    // results are only taken while something is in flight, so stale pipe contents after reset are dropped
    accept = iPC_VALID && state_q != IDLE && (pend_q != '0 || issue);
    last_chunk_in = chunk_q == CW'(NCHUNK - 1);
    last_issue = issue && last_chunk_in && neuron_q == NW'(NOUT - 1);
    retire_last = rc_q == CW'(NCHUNK - 1);
    sum = (rc_q == '0 ? '0 : acc_q) + AW'(iPC_DATA);
    chunk_d = issue ? chunk_q + CW'(1) : chunk_q;
    neuron_d = issue && last_chunk_in ? neuron_q + NW'(1) : neuron_q;
    rc_d = accept ? rc_q + CW'(1) : rc_q;
    rn_d = accept && retire_last ? rn_q + NW'(1) : rn_q;
    acc_d = accept ? sum : acc_q;
    we_d = accept && retire_last;
    out_addr_d = we_d ? rn_q : out_addr_q;
    bit_d = we_d ? sum >= thresh_q : bit_q;
    pend_d = pend_q + OW'(issue) - OW'(accept);
    thresh_d = state_q == IDLE && iSTART ? iTHRESH : thresh_q;
    state_d = state_q == IDLE  ? (iSTART ? ISSUE : IDLE) :
              state_q == ISSUE ? (last_issue ? DRAIN : ISSUE) :
              state_q == DRAIN ? (we_q && out_addr_q == NW'(NOUT - 1) ? DONE : DRAIN) : IDLE;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      chunk_q <= '0;
      neuron_q <= '0;
      rc_q <= '0;
      rn_q <= '0;
      acc_q <= '0;
      thresh_q <= '0;
      pend_q <= '0;
      we_q <= 1'b0;
      out_addr_q <= '0;
      bit_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      neuron_q <= neuron_d;
      rc_q <= rc_d;
      rn_q <= rn_d;
      acc_q <= acc_d;
      thresh_q <= thresh_d;
      pend_q <= pend_d;
      we_q <= we_d;
      out_addr_q <= out_addr_d;
      bit_q <= bit_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign oDATA_ADDR = chunk_q;
  assign oWEIGHT_ADDR = {neuron_q, chunk_q};
  assign oPC_EN = issue;
  assign oOUT_WE = we_q;
  assign oOUT_ADDR = out_addr_q;
  assign oOUT_BIT = bit_q;
  assign oBUSY = busy_q;
  assign oDONE = done_q;
endmodule
